// File: rtl/pipe_stage_reg_if.sv
// Valid/ready bus for one pipeline stage: the upstream entry port and the
// downstream head port, viewed from the driver (master) or the stage (slave).
interface pipe_stage_reg_if #(
  parameter int DATA_W = 32
);
  logic              in_valid;
  logic              in_we;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              out_valid;
  logic              out_we;
  logic [DATA_W-1:0] out_data;
  logic              out_ready;

  modport master (
    output in_valid, in_we, in_data, out_ready,
    input  in_ready, out_valid, out_we, out_data
  );

  modport slave (
    input  in_valid, in_we, in_data, out_ready,
    output in_ready, out_valid, out_we, out_data
  );
endinterface

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with optional skid entry, synchronous flush and a
// saturating back-pressure cycle counter.
module pipe_stage_reg #(
  parameter int DATA_W = 32,
  parameter int SKID   = 1,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  pipe_stage_reg_if.slave  bus,
  input  logic             flush,
  input  logic             clr_cnt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [1:0]       state_dbg
);

  // Handshake: a side transfers on a rising edge where its valid and ready are
  // both 1; valid never depends on ready, and a held head stays unchanged.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t            state, state_n;
  logic [DATA_W-1:0] main_data, skid_data;
  logic              main_we, skid_we;
  logic              load_main, load_skid, main_from_skid;
  logic              in_fire, out_fire;

  // With the skid entry in_ready depends only on state; without it the single
  // entry may be refilled in the same cycle it drains.
  assign bus.in_ready  = (SKID != 0) ? (state != TWO)
                                     : ((state == EMPTY) || bus.out_ready);
  assign bus.out_valid = (state != EMPTY);
  assign bus.out_we    = main_we && (state != EMPTY);
  assign bus.out_data  = main_data;
  assign state_dbg     = state;

  assign in_fire  = bus.in_valid && bus.in_ready;
  assign out_fire = bus.out_valid && bus.out_ready;

  always_comb begin
    state_n        = state;
    load_main      = 1'b0;
    load_skid      = 1'b0;
    main_from_skid = 1'b0;
    case (state)
      EMPTY: begin
        if (in_fire) begin
          state_n   = ONE;
          load_main = 1'b1;
        end
      end
      ONE: begin
        // Without the skid entry in_fire in ONE implies out_fire.
        if (in_fire && out_fire) begin
          load_main = 1'b1;
        end else if (in_fire) begin
          state_n   = TWO;
          load_skid = 1'b1;
        end else if (out_fire) begin
          state_n = EMPTY;
        end
      end
      TWO: begin
        if (out_fire) begin
          state_n        = ONE;
          main_from_skid = 1'b1;
        end
      end
      default: state_n = EMPTY;
    endcase
    if (flush) begin
      state_n        = EMPTY;
      load_main      = 1'b0;
      load_skid      = 1'b0;
      main_from_skid = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= EMPTY;
      main_data <= '0;
      main_we   <= 1'b0;
      skid_data <= '0;
      skid_we   <= 1'b0;
    end else begin
      state <= state_n;
      if (load_main) begin
        main_data <= bus.in_data;
        main_we   <= bus.in_we;
      end else if (main_from_skid) begin
        main_data <= skid_data;
        main_we   <= skid_we;
      end
      if (load_skid) begin
        skid_data <= bus.in_data;
        skid_we   <= bus.in_we;
      end
    end
  end

  // Counts cycles where a valid head is refused; clear beats increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (clr_cnt) begin
      stall_cnt <= '0;
    end else if (bus.out_valid && !bus.out_ready && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: skid variant, narrow-counter variant and no-skid
// variant, each with directed scenarios and an ordered expected-data queue.
module tb_pipe_stage_reg;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  // a: SKID=1, CNT_W=16
  pipe_stage_reg_if #(.DATA_W(32)) a_if ();
  logic        a_flush, a_clr;
  logic [15:0] a_cnt;
  logic [1:0]  a_st;
  pipe_stage_reg #(.DATA_W(32), .SKID(1), .CNT_W(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(a_if.slave), .flush(a_flush),
    .clr_cnt(a_clr), .stall_cnt(a_cnt), .state_dbg(a_st)
  );

  // b: SKID=1, CNT_W=4
  pipe_stage_reg_if #(.DATA_W(8)) b_if ();
  logic       b_flush, b_clr;
  logic [3:0] b_cnt;
  logic [1:0] b_st;
  pipe_stage_reg #(.DATA_W(8), .SKID(1), .CNT_W(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(b_if.slave), .flush(b_flush),
    .clr_cnt(b_clr), .stall_cnt(b_cnt), .state_dbg(b_st)
  );

  // c: SKID=0
  pipe_stage_reg_if #(.DATA_W(16)) c_if ();
  logic        c_flush, c_clr;
  logic [15:0] c_cnt;
  logic [1:0]  c_st;
  pipe_stage_reg #(.DATA_W(16), .SKID(0), .CNT_W(16)) dut_c (
    .clk(clk), .rst_n(rst_n), .bus(c_if.slave), .flush(c_flush),
    .clr_cnt(c_clr), .stall_cnt(c_cnt), .state_dbg(c_st)
  );

  logic [31:0] a_q[$];
  logic [15:0] c_q[$];
  int          c_sent = 0;
  int          c_rx   = 0;

  // Scoreboards: transfers are decided at the next rising edge, so judge them
  // on the falling edge where inputs and outputs are settled.
  always @(negedge clk) begin
    logic [31:0] exp_a;
    if (!rst_n) begin
      a_q.delete();
    end else begin
      if (a_if.out_valid && a_if.out_ready) begin
        total++;
        if (a_q.size() == 0) begin
          bad++;
          $display("FAIL a_sb_extra got=%0h exp=none", a_if.out_data);
        end else begin
          exp_a = a_q.pop_front();
          if (a_if.out_data !== exp_a) begin
            bad++;
            $display("FAIL a_sb_data got=%0h exp=%0h", a_if.out_data, exp_a);
          end
        end
      end
      if (a_flush) a_q.delete();
      else if (a_if.in_valid && a_if.in_ready) a_q.push_back(a_if.in_data);
    end
  end

  always @(negedge clk) begin
    logic [15:0] exp_c;
    if (!rst_n) begin
      c_q.delete();
    end else begin
      if (c_if.out_valid && c_if.out_ready) begin
        total++;
        c_rx++;
        if (c_q.size() == 0) begin
          bad++;
          $display("FAIL c_sb_extra got=%0h exp=none", c_if.out_data);
        end else begin
          exp_c = c_q.pop_front();
          if (c_if.out_data !== exp_c) begin
            bad++;
            $display("FAIL c_sb_data got=%0h exp=%0h", c_if.out_data, exp_c);
          end
        end
      end
      if (c_flush) c_q.delete();
      else if (c_if.in_valid && c_if.in_ready) c_q.push_back(c_if.in_data);
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    #1;
    total++;
    if (a_if.out_valid !== 1'b0 || a_if.in_ready !== 1'b1 || a_if.out_we !== 1'b0) begin
      bad++;
      $display("FAIL reset_hs got=v%b r%b we%b exp=v0 r1 we0",
               a_if.out_valid, a_if.in_ready, a_if.out_we);
    end
    total++;
    if (a_if.out_data !== 32'h0 || a_cnt !== 16'h0 || a_st !== 2'd0) begin
      bad++;
      $display("FAIL reset_state got=d%0h c%0d s%0d exp=0 0 0", a_if.out_data, a_cnt, a_st);
    end
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  task automatic test_stream;
    logic [31:0] exp_d[3];
    exp_d[0] = 32'h1; exp_d[1] = 32'h2; exp_d[2] = 32'h3;
    a_if.out_ready = 1'b1;
    a_if.in_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a_if.in_data = exp_d[i];
      tick();
      total++;
      if (a_if.out_valid !== 1'b1 || a_if.out_data !== exp_d[i] || a_if.in_ready !== 1'b1) begin
        bad++;
        $display("FAIL stream_%0d got=v%b d%0h r%b exp=v1 d%0h r1",
                 i, a_if.out_valid, a_if.out_data, a_if.in_ready, exp_d[i]);
      end
    end
    a_if.in_valid = 1'b0;
    tick();
    total++;
    if (a_if.out_valid !== 1'b0) begin
      bad++;
      $display("FAIL stream_end got=v%b exp=v0", a_if.out_valid);
    end
  endtask

  task automatic test_backpressure;
    a_if.out_ready = 1'b0;
    a_if.in_valid  = 1'b1;
    a_if.in_data   = 32'hA;
    tick();
    a_if.in_data = 32'hB;
    tick();
    a_if.in_valid = 1'b0;
    total++;
    if (a_st !== 2'd2 || a_if.in_ready !== 1'b0 || a_if.out_data !== 32'hA) begin
      bad++;
      $display("FAIL bp_two got=s%0d r%b d%0h exp=s2 r0 dA", a_st, a_if.in_ready, a_if.out_data);
    end
    tick();
    total++;
    if (a_if.out_valid !== 1'b1 || a_if.out_data !== 32'hA) begin
      bad++;
      $display("FAIL bp_hold got=v%b d%0h exp=v1 dA", a_if.out_valid, a_if.out_data);
    end
    a_if.out_ready = 1'b1;
    tick();
    total++;
    if (a_if.out_valid !== 1'b1 || a_if.out_data !== 32'hB) begin
      bad++;
      $display("FAIL bp_second got=v%b d%0h exp=v1 dB", a_if.out_valid, a_if.out_data);
    end
    tick();
    total++;
    if (a_if.out_valid !== 1'b0) begin
      bad++;
      $display("FAIL bp_empty got=v%b exp=v0", a_if.out_valid);
    end
  endtask

  task automatic test_flush;
    a_if.out_ready = 1'b0;
    a_if.in_valid  = 1'b1;
    a_if.in_data   = 32'h11;
    tick();
    a_if.in_data = 32'h12;
    tick();
    a_if.in_data = 32'hC;
    a_flush      = 1'b1;
    tick();
    a_flush       = 1'b0;
    a_if.in_valid = 1'b0;
    total++;
    if (a_if.out_valid !== 1'b0 || a_if.in_ready !== 1'b1 || a_st !== 2'd0) begin
      bad++;
      $display("FAIL flush_state got=v%b r%b s%0d exp=v0 r1 s0",
               a_if.out_valid, a_if.in_ready, a_st);
    end
    a_if.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (a_if.out_valid !== 1'b0) begin
        bad++;
        $display("FAIL flush_ghost_%0d got=v%b d%0h exp=v0", i, a_if.out_valid, a_if.out_data);
      end
    end
  endtask

  task automatic test_we_mask;
    a_if.out_ready = 1'b0;
    a_if.in_valid  = 1'b1;
    a_if.in_we     = 1'b1;
    a_if.in_data   = 32'h55;
    tick();
    a_if.in_valid = 1'b0;
    a_if.in_we    = 1'b0;
    total++;
    if (a_if.out_we !== 1'b1 || a_if.out_valid !== 1'b1) begin
      bad++;
      $display("FAIL we_held got=we%b v%b exp=we1 v1", a_if.out_we, a_if.out_valid);
    end
    a_if.out_ready = 1'b1;
    tick();
    total++;
    if (a_if.out_we !== 1'b0 || a_if.out_valid !== 1'b0) begin
      bad++;
      $display("FAIL we_drained got=we%b v%b exp=we0 v0", a_if.out_we, a_if.out_valid);
    end
  endtask

  task automatic test_stall_sat;
    b_if.out_ready = 1'b0;
    b_if.in_valid  = 1'b1;
    b_if.in_data   = 8'h7;
    tick();
    b_if.in_valid = 1'b0;
    repeat (5) tick();
    total++;
    if (b_cnt !== 4'd5) begin
      bad++;
      $display("FAIL sat_count5 got=%0d exp=5", b_cnt);
    end
    repeat (15) tick();
    total++;
    if (b_cnt !== 4'd15) begin
      bad++;
      $display("FAIL sat_count20 got=%0d exp=15", b_cnt);
    end
    b_clr = 1'b1;
    tick();
    b_clr = 1'b0;
    total++;
    if (b_cnt !== 4'd0) begin
      bad++;
      $display("FAIL sat_clear got=%0d exp=0", b_cnt);
    end
    tick();
    total++;
    if (b_cnt !== 4'd1) begin
      bad++;
      $display("FAIL sat_after_clear got=%0d exp=1", b_cnt);
    end
    b_flush = 1'b1;
    tick();
    b_flush = 1'b0;
    tick();
    total++;
    if (b_cnt !== 4'd2 || b_if.out_valid !== 1'b0) begin
      bad++;
      $display("FAIL sat_flush got=c%0d v%b exp=c2 v0", b_cnt, b_if.out_valid);
    end
    b_if.out_ready = 1'b1;
  endtask

  task automatic test_async_reset;
    a_if.out_ready = 1'b0;
    a_if.in_valid  = 1'b1;
    a_if.in_data   = 32'h66;
    tick();
    a_if.in_valid = 1'b0;
    repeat (2) tick();
    #1;
    rst_n = 1'b0;
    #1;
    total++;
    if (a_if.out_valid !== 1'b0 || a_cnt !== 16'h0 || a_if.in_ready !== 1'b1 ||
        a_if.out_data !== 32'h0) begin
      bad++;
      $display("FAIL async_rst got=v%b c%0d r%b d%0h exp=v0 c0 r1 d0",
               a_if.out_valid, a_cnt, a_if.in_ready, a_if.out_data);
    end
    tick();
    rst_n          = 1'b1;
    a_if.out_ready = 1'b1;
    a_if.in_valid  = 1'b1;
    a_if.in_data   = 32'h77;
    tick();
    a_if.in_valid = 1'b0;
    total++;
    if (a_if.out_valid !== 1'b1 || a_if.out_data !== 32'h77) begin
      bad++;
      $display("FAIL post_rst got=v%b d%0h exp=v1 d77", a_if.out_valid, a_if.out_data);
    end
    tick();
  endtask

  task automatic test_skid0_stream;
    logic fired;
    c_if.in_data = 16'($urandom_range(0, 65535));
    for (int i = 0; i < 30; i++) begin
      if (i < 15) begin
        c_if.out_ready = (i % 3 == 1) ? 1'b0 : 1'b1;
        c_if.in_valid  = 1'b1;
      end else begin
        c_if.out_ready = 1'($urandom_range(0, 1));
        c_if.in_valid  = 1'($urandom_range(0, 1));
      end
      #1;
      fired = c_if.in_valid && c_if.in_ready;
      tick();
      if (fired) begin
        c_sent++;
        c_if.in_data = 16'($urandom_range(0, 65535));
      end
    end
    c_if.in_valid  = 1'b0;
    c_if.out_ready = 1'b1;
    repeat (3) tick();
    total++;
    if (c_rx !== c_sent || c_q.size() != 0) begin
      bad++;
      $display("FAIL skid0_count got=rx%0d left%0d exp=rx%0d left0", c_rx, c_q.size(), c_sent);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    a_if.in_valid = 1'b0; a_if.in_we = 1'b0; a_if.in_data = '0; a_if.out_ready = 1'b0;
    b_if.in_valid = 1'b0; b_if.in_we = 1'b0; b_if.in_data = '0; b_if.out_ready = 1'b0;
    c_if.in_valid = 1'b0; c_if.in_we = 1'b0; c_if.in_data = '0; c_if.out_ready = 1'b0;
    a_flush = 1'b0; a_clr = 1'b0;
    b_flush = 1'b0; b_clr = 1'b0;
    c_flush = 1'b0; c_clr = 1'b0;

    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_we_mask();
    test_stall_sat();
    test_async_reset();
    test_skid0_stream();

    total++;
    if (a_q.size() != 0) begin
      bad++;
      $display("FAIL a_sb_leftover got=%0d exp=0", a_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning the payload width in bits (range 1..256).
REQ-002 The block SHALL have parameter SKID, default 1, meaning skid entry present (1) or absent (0).
REQ-003 The block SHALL have parameter CNT_W, default 16, meaning the stall counter width in bits.
REQ-004 The block SHALL have port clk, input, width 1, the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst_n, input, width 1, the reset: asynchronous, active-low.
REQ-006 The block SHALL have port in_valid, input, width 1, the upstream entry valid.
REQ-007 The block SHALL have port in_we, input, width 1, the register-file write enable of the upstream entry.
REQ-008 The block SHALL have port in_data, input, width DATA_W, the upstream payload.
REQ-009 The block SHALL have port in_ready, output, width 1, meaning the stage can accept an entry this cycle.
REQ-010 The block SHALL have port out_valid, output, width 1, meaning the head entry is valid.
REQ-011 The block SHALL have port out_we, output, width 1, the head write enable, forced 0 when out_valid=0.
REQ-012 The block SHALL have port out_data, output, width DATA_W, the head payload.
REQ-013 The block SHALL have port out_ready, input, width 1, meaning downstream accepts the head this cycle.
REQ-014 The block SHALL have port flush, input, width 1, a synchronous kill of all held entries.
REQ-015 The block SHALL have port clr_cnt, input, width 1, a synchronous clear of stall_cnt.
REQ-016 The block SHALL have port stall_cnt, output, width CNT_W, the saturating count of back-pressured cycles.

Function
REQ-017 Transfers: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
REQ-018 Entry order SHALL be preserved; each accepted entry SHALL be presented exactly once unless flushed.
REQ-019 With SKID=1, the block SHALL be a 3-state machine over EMPTY, ONE (main full) and TWO (main+skid full); out_valid=(state!=EMPTY); in_ready=(state!=TWO), registered, with no combinational path from out_ready.
REQ-020 EMPTY: in_fire -> ONE, main<=in.
REQ-021 ONE: in_fire&out_fire -> ONE, main<=in; in_fire&!out_fire -> TWO, skid<=in; out_fire only -> EMPTY; neither -> hold.
REQ-022 TWO: out_fire -> ONE, main<=skid; otherwise hold; no in_fire is possible in this state.
REQ-023 With SKID=0, the block SHALL have one entry; in_ready = !out_valid | out_ready (combinational); in_fire loads main; out_fire without in_fire empties the stage.
REQ-024 Latency SHALL be 1 cycle: an entry accepted at edge N is visible on out_* after edge N when the stage was EMPTY or draining.
REQ-025 Held entries SHALL keep out_data/out_we stable while out_valid=1 and out_ready=0.
REQ-026 flush SHALL have the highest priority: next state EMPTY, and any in_fire in the same cycle is discarded; in_ready is not gated by flush.
REQ-027 stall_cnt SHALL increment by 1 each cycle with out_valid=1 & out_ready=0, and saturate at 2^CNT_W-1 (no wrap).
REQ-028 clr_cnt SHALL force stall_cnt to 0 next cycle, overriding a simultaneous increment.
REQ-029 flush SHALL NOT affect stall_cnt.

Reset
REQ-030 While rst_n=0, the block SHALL immediately (without a clock) set state EMPTY, out_valid=0, out_we=0, out_data=0, skid data=0 and stall_cnt=0.
REQ-031 While rst_n=0, in_ready SHALL be 1.
REQ-032 Reset asserted mid-transfer SHALL discard all entries; the first edge after rst_n rises SHALL accept input normally.

Verification
REQ-033 The bench SHALL cover streaming: SKID=1, in_valid=1 every cycle with data 0x1,0x2,0x3 and out_ready=1 -> out_data 0x1,0x2,0x3 on consecutive cycles, in_ready held at 1.
REQ-034 The bench SHALL cover back-pressure: out_ready=0 while sending 0xA then 0xB -> state TWO, in_ready=0, out_data=0xA steady; with out_ready=1 for 2 cycles -> 0xA then 0xB, then out_valid=0.
REQ-035 The bench SHALL cover flush collision: state TWO with flush=1 and in_valid=1 (data 0xC) -> next cycle out_valid=0, in_ready=1, and 0xC never appears.
REQ-036 The bench SHALL cover out_we masking: accept in_we=1 then drain -> out_we=1 only while out_valid=1, and 0 in the cycle after the drain.
REQ-037 The bench SHALL cover counter saturation: CNT_W=4 with 20 stalled cycles -> stall_cnt=15; clr_cnt=1 during a stall -> stall_cnt=0 next cycle, then 1.
REQ-038 The bench SHALL cover async reset: rst_n pulled low between clock edges while in state ONE -> out_valid=0 and stall_cnt=0 before the next edge; SKID=0 streaming with out_ready toggling 1,0,1 -> no loss or duplication.
